// File: rtl/kmkz_writeback.sv
// -----------------------------------------------------------------------------
// kmkz_writeback
//
// Writeback stage of the Kamikaze-uRV pipeline. Registers the execute-stage
// result, aligns and sign-extends data-memory load responses, drives the
// register-file write port and the W-stage bypass, and stalls the pipeline
// while a load response is outstanding.
//
// Optional feature: define KMKZ_WB_LOAD_TIMEOUT_EN to enable the load-response
// watchdog. Without it w_load_fault_o is tied 0 and a load waits indefinitely.
//
// Parameters:
//   TIMEOUT_CYCLES      watchdog limit in cycles (1..255), watchdog build only
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-low reset
//   x_valid_i           execute stage presents an instruction this cycle
//   x_rd_i              destination register
//   x_rd_write_i        instruction writes rd
//   x_rd_value_i        ALU/CSR result (ignored for loads)
//   x_load_i            instruction is a load
//   x_fun_i             RV32 load funct3
//   x_addr_lo_i         load address bits [1:0]
//   dm_data_l_i         data-memory read word
//   dm_load_done_i      load data valid, single-cycle pulse
//   w_rd_o              register-file write address
//   w_rd_value_o        register-file write data
//   w_rd_store_o        register-file write enable
//   w_bypass_rd_write_o bypass value valid for w_rd_o
//   w_bypass_rd_value_o bypass value (always equal to w_rd_value_o)
//   w_stall_req_o       pipeline stall request
//   w_load_fault_o      watchdog expiry, one-cycle pulse
//   dbg_state_o         FSM state (0 = IDLE, 1 = LOAD_WAIT)
//
// Handshake: the stage register accepts the x_* bundle on every rising edge
// where w_stall_req_o is low (x_valid_i=0 enters as a bubble). While
// w_stall_req_o is high the stage holds and upstream must hold x_* stable.
// -----------------------------------------------------------------------------
module kmkz_writeback #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_valid_i,
    input  logic [4:0]  x_rd_i,
    input  logic        x_rd_write_i,
    input  logic [31:0] x_rd_value_i,
    input  logic        x_load_i,
    input  logic [2:0]  x_fun_i,
    input  logic [1:0]  x_addr_lo_i,
    input  logic [31:0] dm_data_l_i,
    input  logic        dm_load_done_i,
    output logic [4:0]  w_rd_o,
    output logic [31:0] w_rd_value_o,
    output logic        w_rd_store_o,
    output logic        w_bypass_rd_write_o,
    output logic [31:0] w_bypass_rd_value_o,
    output logic        w_stall_req_o,
    output logic        w_load_fault_o,
    output logic        dbg_state_o
);

    typedef enum logic {
        S_IDLE      = 1'b0,
        S_LOAD_WAIT = 1'b1
    } state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("kmkz_writeback: TIMEOUT_CYCLES must be in 1..255");
    end

    state_t      state;

    // Stage register
    logic        s_valid;
    logic [4:0]  s_rd;
    logic        s_write;
    logic [31:0] s_value;
    logic        s_load;
    logic [2:0]  s_fun;
    logic [1:0]  s_addr_lo;

    logic        load_pending;
    logic        expiry;
    logic        complete;
    logic        store;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_aligned;
    logic [31:0] wb_value;

    assign load_pending = s_valid & s_load;

`ifdef KMKZ_WB_LOAD_TIMEOUT_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wd_cnt;

    // The counter restarts whenever the stage accepts a new instruction, so it
    // reads 0 in a load's first W cycle and counts every cycle spent stalled.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wd_cnt <= 8'd0;
        end else if (!w_stall_req_o) begin
            wd_cnt <= 8'd0;
        end else begin
            wd_cnt <= wd_cnt + 8'd1;
        end
    end

    // A same-cycle done takes priority over expiry.
    assign expiry = load_pending & ~dm_load_done_i & (wd_cnt == WD_LAST);
`else
    assign expiry = 1'b0;
`endif

    // Combinational so the stall drops in the very cycle the load completes.
    assign w_stall_req_o  = load_pending & ~dm_load_done_i & ~expiry;
    assign w_load_fault_o = expiry;

    // Non-loads complete in their first W cycle; loads on done or expiry.
    assign complete = s_valid & (~s_load | dm_load_done_i | expiry);
    assign store    = complete & s_write & (s_rd != 5'd0);

    // Load data alignment
    always_comb begin
        ld_byte = dm_data_l_i[7:0];
        case (s_addr_lo)
            2'd0: ld_byte = dm_data_l_i[7:0];
            2'd1: ld_byte = dm_data_l_i[15:8];
            2'd2: ld_byte = dm_data_l_i[23:16];
            2'd3: ld_byte = dm_data_l_i[31:24];
            default: ld_byte = dm_data_l_i[7:0];
        endcase
        // Half select ignores addr_lo[0]
        ld_half = s_addr_lo[1] ? dm_data_l_i[31:16] : dm_data_l_i[15:0];
        case (s_fun)
            3'b000:  ld_aligned = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_aligned = {24'd0, ld_byte};
            3'b001:  ld_aligned = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_aligned = {16'd0, ld_half};
            default: ld_aligned = dm_data_l_i;
        endcase
    end

    // An expired load retires with value 0.
    always_comb begin
        wb_value = s_value;
        if (s_load) begin
            wb_value = expiry ? 32'd0 : ld_aligned;
        end
    end

    assign w_rd_o              = s_rd;
    assign w_rd_value_o        = wb_value;
    assign w_bypass_rd_value_o = wb_value;
    assign w_rd_store_o        = store;
    assign w_bypass_rd_write_o = store;
    assign dbg_state_o         = state;

    // Stage register: holds during a stall, otherwise captures x_* (bubbles
    // included) every edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s_valid   <= 1'b0;
            s_rd      <= 5'd0;
            s_write   <= 1'b0;
            s_value   <= 32'd0;
            s_load    <= 1'b0;
            s_fun     <= 3'd0;
            s_addr_lo <= 2'd0;
        end else if (!w_stall_req_o) begin
            s_valid   <= x_valid_i;
            s_rd      <= x_rd_i;
            s_write   <= x_rd_write_i;
            s_value   <= x_rd_value_i;
            s_load    <= x_load_i;
            s_fun     <= x_fun_i;
            s_addr_lo <= x_addr_lo_i;
        end
    end

    // FSM: tracks whether the stage is waiting on a load response.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:      if (w_stall_req_o)  state <= S_LOAD_WAIT;
                S_LOAD_WAIT: if (!w_stall_req_o) state <= S_IDLE;
                default:     state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kmkz_writeback.sv
// -----------------------------------------------------------------------------
// Testbench for kmkz_writeback. Directed instructions from the test plan are
// followed by randomized instruction streams with random load latencies. A
// transaction-level model decides, per W cycle, whether the instruction in W
// stalls, completes, expires and what it writes. A final reset-during-load
// scenario closes the run.
// -----------------------------------------------------------------------------
module tb_kmkz_writeback;

`ifdef KMKZ_WB_LOAD_TIMEOUT_EN
    localparam int TB_TMO = 4;
`else
    localparam int TB_TMO = 255;
`endif

    // Clock / reset
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        x_valid_i, x_rd_write_i, x_load_i, dm_load_done_i;
    logic [4:0]  x_rd_i;
    logic [31:0] x_rd_value_i, dm_data_l_i;
    logic [2:0]  x_fun_i;
    logic [1:0]  x_addr_lo_i;
    logic [4:0]  w_rd_o;
    logic [31:0] w_rd_value_o, w_bypass_rd_value_o;
    logic        w_rd_store_o, w_bypass_rd_write_o, w_stall_req_o, w_load_fault_o;
    logic        dbg_state_o;

    kmkz_writeback #(.TIMEOUT_CYCLES(TB_TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .x_valid_i(x_valid_i), .x_rd_i(x_rd_i), .x_rd_write_i(x_rd_write_i),
        .x_rd_value_i(x_rd_value_i), .x_load_i(x_load_i), .x_fun_i(x_fun_i),
        .x_addr_lo_i(x_addr_lo_i), .dm_data_l_i(dm_data_l_i),
        .dm_load_done_i(dm_load_done_i),
        .w_rd_o(w_rd_o), .w_rd_value_o(w_rd_value_o), .w_rd_store_o(w_rd_store_o),
        .w_bypass_rd_write_o(w_bypass_rd_write_o),
        .w_bypass_rd_value_o(w_bypass_rd_value_o),
        .w_stall_req_o(w_stall_req_o), .w_load_fault_o(w_load_fault_o),
        .dbg_state_o(dbg_state_o)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  rd;
        logic        wr;
        logic [31:0] val;
        logic        ld;
        logic [2:0]  fun;
        logic [1:0]  lo;
        int          delay;   // cycles after entering W before done arrives
        logic [31:0] data;
        logic        has_lit;
        logic [31:0] lit;     // hand-computed write value
    } instr_t;

    instr_t instr_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard compare
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    function automatic instr_t mk(input logic v, input logic [4:0] rd, input logic wr,
                                  input logic [31:0] val, input logic ld, input logic [2:0] fun,
                                  input logic [1:0] lo, input int delay, input logic [31:0] data,
                                  input logic has_lit, input logic [31:0] lit);
        instr_t t;
        t.valid = v; t.rd = rd; t.wr = wr; t.val = val; t.ld = ld; t.fun = fun;
        t.lo = lo; t.delay = delay; t.data = data; t.has_lit = has_lit; t.lit = lit;
        return t;
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        t.valid   = ($urandom_range(0, 3) != 0);
        t.rd      = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        t.wr      = ($urandom_range(0, 4) != 0);
        t.val     = $urandom;
        t.ld      = $urandom_range(0, 1) == 1;
        t.fun     = 3'($urandom_range(0, 7));
        t.lo      = 2'($urandom_range(0, 3));
        t.delay   = $urandom_range(0, 5);
        t.data    = $urandom;
        t.has_lit = 1'b0;
        t.lit     = 32'd0;
        return t;
    endfunction

    // Reference load formatting from the funct3 rules, using plain arithmetic.
    function automatic logic [31:0] model_align(input logic [2:0] f, input logic [1:0] a,
                                                input logic [31:0] d);
        logic [31:0] b, h;
        b = (d >> (int'(a) * 8)) & 32'hFF;
        h = (d >> (int'(a[1]) * 16)) & 32'hFFFF;
        case (f)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            default: return d;
        endcase
    endfunction

    task automatic drive_x(input instr_t t);
        x_valid_i    = t.valid;
        x_rd_i       = t.rd;
        x_rd_write_i = t.wr;
        x_rd_value_i = t.val;
        x_load_i     = t.ld;
        x_fun_i      = t.fun;
        x_addr_lo_i  = t.lo;
    endtask

    initial begin
        instr_t cur, pres, bubble;
        int     wcyc;
        int     cycles;
        logic   exp_stall, prev_stall, done_now, expire, exp_store;
        logic [31:0] exp_val;

        bubble = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_x(bubble);
        dm_load_done_i = 1'b0;
        dm_data_l_i    = 32'd0;

        // Reset state
        repeat (2) @(negedge clk_i);
        check("rst_store", w_rd_store_o, 0);
        check("rst_byp_wr", w_bypass_rd_write_o, 0);
        check("rst_stall", w_stall_req_o, 0);
        check("rst_rd", w_rd_o, 0);
        check("rst_value", w_rd_value_o, 0);
        check("rst_byp_val", w_bypass_rd_value_o, 0);
        check("rst_fault", w_load_fault_o, 0);
        check("rst_state", dbg_state_o, 0);
        rst_i = 1'b1;

        // Directed instructions
        instr_q.push_back(mk(1, 5, 1, 32'h12345678, 0, 0, 0, 0, 0, 1, 32'h12345678));
        instr_q.push_back(mk(1, 3, 1, 32'hDEAD0000, 1, 3'b000, 3, 0, 32'h80FF_0000, 1, 32'hFFFF_FF80));
        instr_q.push_back(mk(1, 4, 1, 32'hDEAD0001, 1, 3'b100, 3, 0, 32'h80FF_0000, 1, 32'h0000_0080));
        instr_q.push_back(mk(1, 6, 1, 32'hDEAD0002, 1, 3'b001, 2, 3, 32'h8001_7FFF, 1, 32'hFFFF_8001));
        instr_q.push_back(mk(1, 7, 1, 32'h0BAD_F00D, 0, 0, 0, 0, 0, 1, 32'h0BAD_F00D));
        instr_q.push_back(mk(1, 0, 1, 32'h5555_AAAA, 0, 0, 0, 0, 0, 0, 0));
        instr_q.push_back(mk(1, 0, 1, 32'h0, 1, 3'b010, 0, 2, 32'hCAFE_BABE, 0, 0));
`ifdef KMKZ_WB_LOAD_TIMEOUT_EN
        instr_q.push_back(mk(1, 9, 1, 32'h1111_1111, 1, 3'b010, 0, 10, 32'hFFFF_FFFF, 1, 32'h0));
`else
        instr_q.push_back(mk(1, 9, 1, 32'h1111_1111, 1, 3'b010, 0, 10, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF));
`endif
        instr_q.push_back(mk(1, 10, 1, 32'h2222_2222, 0, 0, 0, 0, 0, 1, 32'h2222_2222));
        for (int i = 0; i < 400; i++) instr_q.push_back(rand_instr());

        // Cycle-stepped model and compare
        cur        = bubble;
        pres       = bubble;
        wcyc       = 0;
        cycles     = 0;
        exp_stall  = 1'b0;
        prev_stall = 1'b0;
        forever begin
            @(posedge clk_i);
            prev_stall = exp_stall;
            if (!exp_stall) begin
                cur  = pres;
                wcyc = 0;
                pres = (instr_q.size() > 0) ? instr_q.pop_front() : rand_instr();
                if (instr_q.size() == 0) pres.valid = 1'b0;
            end else begin
                wcyc++;
            end
            #1;
            drive_x(pres);
            done_now = cur.valid && cur.ld && (wcyc == cur.delay);
            expire   = cur.valid && cur.ld && !done_now && (wcyc == TB_TMO - 1);
            if (TB_TMO == 255) expire = 1'b0;
            exp_stall = cur.valid && cur.ld && !done_now && !expire;
            if (cur.valid && cur.ld) dm_load_done_i = done_now;
            else dm_load_done_i = ($urandom_range(0, 3) == 0);
            dm_data_l_i = done_now ? cur.data : $urandom;

            exp_store = cur.valid && (!cur.ld || done_now || expire) && cur.wr && (cur.rd != 0);
            exp_val   = cur.ld ? (expire ? 32'd0 : model_align(cur.fun, cur.lo, cur.data)) : cur.val;

            @(negedge clk_i);
            check("stall", w_stall_req_o, exp_stall);
            check("store", w_rd_store_o, exp_store);
            check("byp_wr", w_bypass_rd_write_o, exp_store);
            check("fault", w_load_fault_o, expire);
            check("state", dbg_state_o, prev_stall);
            if (exp_store) begin
                check("rd", w_rd_o, cur.rd);
                check("value", w_rd_value_o, exp_val);
                check("byp_val", w_bypass_rd_value_o, exp_val);
                if (cur.has_lit) check("lit_value", w_rd_value_o, cur.lit);
            end
            cycles++;
            if (cycles > 20000) begin
                check("cycle_budget", 32'(cycles), 32'd20000);
                break;
            end
            if (instr_q.size() == 0 && !pres.valid && !cur.valid && !exp_stall) break;
        end

        // Reset during a pending load, then a stray done
        @(posedge clk_i);
        #1;
        drive_x(mk(1, 7, 1, 32'h0, 1, 3'b010, 0, 0, 0, 0, 0));
        dm_load_done_i = 1'b0;
        @(posedge clk_i);
        #1;
        drive_x(bubble);
        @(negedge clk_i);
        check("rl_stall0", w_stall_req_o, 1);
        @(negedge clk_i);
        check("rl_stall1", w_stall_req_o, 1);
        check("rl_state", dbg_state_o, 1);
        rst_i = 1'b0;
        #1;
        check("rl_stall_rst", w_stall_req_o, 0);
        check("rl_store_rst", w_rd_store_o, 0);
        check("rl_rd_rst", w_rd_o, 0);
        check("rl_val_rst", w_rd_value_o, 0);
        check("rl_state_rst", dbg_state_o, 0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        dm_load_done_i = 1'b1;
        dm_data_l_i    = 32'h7777_7777;
        @(negedge clk_i);
        check("rl_stray_store", w_rd_store_o, 0);
        check("rl_stray_byp", w_bypass_rd_write_o, 0);
        check("rl_stray_stall", w_stall_req_o, 0);
        check("rl_stray_state", dbg_state_o, 0);
        check("rl_stray_fault", w_load_fault_o, 0);
        dm_load_done_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
